// File: rtl/serial_reg_decoder.sv
// Serial nibble-pair register decoder: 10-bit frames on sdi (sampled on sck rising edge)
// assemble 8-bit writes into NUM_REGS registers. Optional even parity: define DECODER_PARITY_EN.
module serial_reg_decoder #(
  parameter int NUM_REGS = 4
) (
  input  logic                  sck,
  input  logic                  rst,
  input  logic                  sdi,
  output logic [NUM_REGS*8-1:0] reg_q,
  output logic [NUM_REGS-1:0]   wr_stb,
  output logic                  change,
  output logic                  frame_err,
  output logic [3:0]            err_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_BREAK  = 3'd4
  } state_t;

  state_t     state_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] payload_r;
  logic [3:0] hold_r;
  logic [2:0] idx_s;
  logic       idx_ok_s;
  logic       parity_ok_s;

`ifdef DECODER_PARITY_EN
  logic       parity_r;

  function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
    even_parity_ok = ~(^{data, par});
  endfunction
`endif

  // Field decode of the assembled payload and frame-check result
  always_comb begin
    idx_s    = payload_r[7:5];
    idx_ok_s = ({1'b0, idx_s} < 4'(NUM_REGS));
`ifdef DECODER_PARITY_EN
    parity_ok_s = even_parity_ok(payload_r, parity_r);
`else
    parity_ok_s = 1'b1;
`endif
  end

  // Frame state machine with registered register bank and status outputs
  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      payload_r <= 8'd0;
      hold_r    <= 4'd0;
      reg_q     <= '0;
      wr_stb    <= '0;
      change    <= 1'b0;
      frame_err <= 1'b0;
      err_count <= 4'd0;
`ifdef DECODER_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      wr_stb    <= '0;
      frame_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!sdi) begin
            state_r   <= ST_DATA;
            bit_cnt_r <= 3'd0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DATA: begin
          payload_r <= {sdi, payload_r[7:1]};
          bit_cnt_r <= bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
`ifdef DECODER_PARITY_EN
            state_r <= ST_PARITY;
`else
            state_r <= ST_STOP;
`endif
          end else begin
            state_r <= ST_DATA;
          end
        end
        ST_PARITY: begin
`ifdef DECODER_PARITY_EN
          parity_r <= sdi;
          state_r  <= ST_STOP;
`else
          state_r  <= ST_IDLE;
`endif
        end
        ST_STOP: begin
          if (sdi && parity_ok_s) begin
            hold_r <= payload_r[3:0];
            // Out-of-range indices still refresh hold but never write or toggle
            if (payload_r[4] && idx_ok_s) begin
              change <= ~change;
              for (int n = 0; n < NUM_REGS; n++) begin
                if (idx_s == 3'(n)) begin
                  reg_q[8*n +: 8] <= {payload_r[3:0], hold_r};
                  wr_stb[n]       <= 1'b1;
                end
              end
            end
            state_r <= ST_IDLE;
          end else begin
            frame_err <= 1'b1;
            if (err_count != 4'd15) begin
              err_count <= err_count + 4'd1;
            end
            state_r <= ST_BREAK;
          end
        end
        ST_BREAK: begin
          // Wait for a high line so a data zero is never mistaken for a start bit
          if (sdi) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_BREAK;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_reg_decoder.sv
// Self-checking bench for serial_reg_decoder: directed test-plan steps plus random frames,
// checked against a frame-level reference model. Two instances: NUM_REGS=4 and NUM_REGS=8.
module tb_serial_reg_decoder;

`ifdef DECODER_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  logic        sck = 1'b0;
  logic        rst;
  logic        sdi;
  logic [31:0] reg_q4;
  logic [3:0]  stb4;
  logic        ch4, fe4;
  logic [3:0]  ec4;
  logic [63:0] reg_q8;
  logic [7:0]  stb8;
  logic        ch8, fe8;
  logic [3:0]  ec8;

  serial_reg_decoder #(.NUM_REGS(4)) u4 (
    .sck(sck), .rst(rst), .sdi(sdi), .reg_q(reg_q4), .wr_stb(stb4),
    .change(ch4), .frame_err(fe4), .err_count(ec4)
  );

  serial_reg_decoder #(.NUM_REGS(8)) u8 (
    .sck(sck), .rst(rst), .sdi(sdi), .reg_q(reg_q8), .wr_stb(stb8),
    .change(ch8), .frame_err(fe8), .err_count(ec8)
  );

  always #5 sck = ~sck;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [7:0] m_reg [0:7];
  logic [3:0] m_hold;
  logic       m_ch4, m_ch8;
  int         m_err;
  int         m_stb4_n = 0, m_stb8_n = 0, m_fe_n = 0;

  // observed pulse counters (high samples on the falling edge)
  int obs_stb4_n = 0, obs_stb8_n = 0, obs_fe4_n = 0, obs_fe8_n = 0;

  always @(negedge sck) begin
    obs_stb4_n += $countones(stb4);
    obs_stb8_n += $countones(stb8);
    obs_fe4_n  += int'(fe4);
    obs_fe8_n  += int'(fe8);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    m_hold = 4'h0;
    m_ch4  = 1'b0;
    m_ch8  = 1'b0;
    m_err  = 0;
  endtask

  task automatic bit_out(input logic b);
    sdi = b;
    @(posedge sck);
    #1;
  endtask

  task automatic check_state(input string tag);
    logic [31:0] e4;
    logic [63:0] e8;
    for (int i = 0; i < 4; i++) e4[8*i +: 8] = m_reg[i];
    for (int i = 0; i < 8; i++) e8[8*i +: 8] = m_reg[i];
    check({tag, "_reg4"}, 64'(reg_q4), 64'(e4));
    check({tag, "_reg8"}, reg_q8, e8);
    check({tag, "_chg4"}, 64'(ch4), 64'(m_ch4));
    check({tag, "_chg8"}, 64'(ch8), 64'(m_ch8));
    check({tag, "_ec4"}, 64'(ec4), 64'(m_err));
    check({tag, "_ec8"}, 64'(ec8), 64'(m_err));
  endtask

  // Send one frame (no trailing idle), update the model, check the stop-edge outputs
  task automatic frame(input string tag, input logic [7:0] p, input logic stop_b, input logic par_flip);
    logic       ok;
    logic [3:0] e_stb4;
    logic [7:0] e_stb8;
    logic       e_fe;
    int         idx;
    ok     = stop_b && !(par_flip && PARITY_ON);
    e_stb4 = 4'h0;
    e_stb8 = 8'h00;
    e_fe   = 1'b0;
    idx    = int'(p[7:5]);
    if (ok) begin
      if (p[4]) begin
        m_reg[idx] = {p[3:0], m_hold};
        e_stb8[idx] = 1'b1;
        m_ch8 = ~m_ch8;
        m_stb8_n++;
        if (idx < 4) begin
          e_stb4[idx] = 1'b1;
          m_ch4 = ~m_ch4;
          m_stb4_n++;
        end
      end
      m_hold = p[3:0];
    end else begin
      e_fe = 1'b1;
      m_fe_n++;
      if (m_err < 15) m_err++;
    end
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(p[i]);
`ifdef DECODER_PARITY_EN
    bit_out((^p) ^ par_flip);
`endif
    bit_out(stop_b);
    check({tag, "_stb4"}, 64'(stb4), 64'(e_stb4));
    check({tag, "_stb8"}, 64'(stb8), 64'(e_stb8));
    check({tag, "_ferr4"}, 64'(fe4), 64'(e_fe));
    check({tag, "_ferr8"}, 64'(fe8), 64'(e_fe));
    check_state(tag);
  endtask

  task automatic idle_after_err(input string tag);
    bit_out(1'b1);
    check({tag, "_ferr_low"}, 64'(fe4 | fe8), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sdi = 1'b1;
    @(posedge sck);
    @(posedge sck);
    #3;
    rst = 1'b0;
    model_reset();
    @(posedge sck);
    #1;
  endtask

  initial begin
    int fe_before;
    model_reset();
    rst = 1'b1;
    sdi = 1'b1;
    #1;
    check("reset_all", {reg_q8, 4'(reg_q4 != 32'd0), stb4, stb8, ch4, ch8, fe4, fe8, ec4, ec8},
          64'd0);
    do_reset();
    check_state("reset");
    bit_out(1'b1);

    // reg 0 from a nibble pair, back-to-back frames
    frame("p05", 8'h05, 1'b1, 1'b0);
    frame("p1a", 8'h1A, 1'b1, 1'b0);
    check("reg0_a5", 64'(reg_q4[7:0]), 64'h A5);
    check("chg_set", 64'(ch4), 64'd1);
    bit_out(1'b1);
    check("stb_one_cycle", 64'({stb4, stb8}), 64'd0);

    // index 7: written only in the 8-register instance
    frame("p03", 8'h03, 1'b1, 1'b0);
    frame("pf7", 8'hF7, 1'b1, 1'b0);
    check("reg7_73", 64'(reg_q8[63:56]), 64'h73);
    check("u4_no_err", 64'(ec4), 64'd0);
    // hold reuse: a lone high-nibble frame pairs with the stored 7
    frame("p10", 8'h10, 1'b1, 1'b0);
    check("reg0_07", 64'(reg_q4[7:0]), 64'h07);
    bit_out(1'b1);

    // framing error, stuck-low line, then resync
    frame("stop0", 8'h25, 1'b0, 1'b0);
    check("ec_one", 64'(ec4), 64'd1);
    for (int i = 0; i < 20; i++) bit_out(1'b0);
    idle_after_err("stuck");
    frame("p02", 8'h02, 1'b1, 1'b0);
    frame("p34", 8'h34, 1'b1, 1'b0);
    check("reg1_42", 64'(reg_q4[15:8]), 64'h42);
    bit_out(1'b1);

    // saturating error counter
    fe_before = obs_fe4_n;
    for (int i = 0; i < 17; i++) begin
      frame("sat", 8'($urandom), 1'b0, 1'b0);
      idle_after_err("sat");
    end
    check("ec_sat", 64'(ec4), 64'd15);
    check("fe_pulses17", 64'(obs_fe4_n - fe_before), 64'd17);

    // asynchronous reset in the middle of a frame
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_reg4", 64'(reg_q4), 64'd0);
    check("midrst_reg8", reg_q8, 64'd0);
    check("midrst_flags", 64'({stb4, stb8, ch4, ch8, fe4, fe8}), 64'd0);
    check("midrst_ec", 64'({ec4, ec8}), 64'd0);
    do_reset();
    frame("p0c", 8'h0C, 1'b1, 1'b0);
    frame("p5b", 8'h5B, 1'b1, 1'b0);
    check("reg2_bc", 64'(reg_q4[23:16]), 64'h BC);
    bit_out(1'b1);

`ifdef DECODER_PARITY_EN
    frame("par05", 8'h05, 1'b1, 1'b0);
    frame("par1a", 8'h1A, 1'b1, 1'b0);
    check("par_reg0_a5", 64'(reg_q4[7:0]), 64'h A5);
    bit_out(1'b1);
    frame("parbad", 8'h1A, 1'b1, 1'b1);
    check("parbad_reg0", 64'(reg_q4[7:0]), 64'h A5);
    idle_after_err("parbad");
`endif

    // random frames with occasional errors and random idle gaps
    do_reset();
    for (int n = 0; n < 150; n++) begin
      logic [7:0] p;
      int r;
      p = 8'($urandom);
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        frame("rnd", p, 1'b0, 1'b0);
        idle_after_err("rnd");
      end else if (r == 1 && PARITY_ON) begin
        frame("rndpar", p, 1'b1, 1'b1);
        idle_after_err("rndpar");
      end else begin
        frame("rnd", p, 1'b1, 1'b0);
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) bit_out(1'b1);
      end
    end
    bit_out(1'b1);
    bit_out(1'b1);

    check("cnt_stb4", 64'(obs_stb4_n), 64'(m_stb4_n));
    check("cnt_stb8", 64'(obs_stb8_n), 64'(m_stb8_n));
    check("cnt_fe4", 64'(obs_fe4_n), 64'(m_fe_n));
    check("cnt_fe8", 64'(obs_fe8_n), 64'(m_fe_n));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
